// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/alarm blocks.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE,
        DONE
    } ring_state_t;

    localparam int unsigned NDAYS = 7;
    localparam logic [NDAYS-1:0] WEEKDAY_MASK = 7'b0011111;

    // Index 7 is not a real day and never qualifies.
    function automatic logic day_enabled(input logic [NDAYS-1:0] mask, input logic [2:0] day);
        logic [7:0] m;
        m = {1'b0, mask};
        return m[day];
    endfunction

endpackage

// File: rtl/alarm_ring_ctrl_edge_rise.sv
// One-bit rising-edge detector; the history register's reset value is a parameter.
module edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing controller: gated trigger, beeping burst, snooze, dismiss and timeout.
module alarm_ring_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned      RING_S   = 60,
    parameter int unsigned      SNOOZE_S = 540,
    parameter int unsigned      MAX_SNZ  = 3,
    parameter logic [NDAYS-1:0] DAY_MASK = WEEKDAY_MASK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       match,
    input  logic       alarm_on,
    input  logic [2:0] day,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzz,
    output logic       ringing,
    output logic [1:0] snz_left
);

    localparam int unsigned TMR_MAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] RING_LAST = TW'(RING_S - 1);
    localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_S - 1);
    localparam logic [1:0]    SNZ_INIT  = 2'(MAX_SNZ);

    ring_state_t   state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          phase, phase_n;
    logic [1:0]    snz_n;
    logic          match_rise, snooze_rise, dismiss_rise;

    // History registers reset high so a level already present at release is not an edge.
    edge_rise #(.RST_VAL(1'b1)) u_match_edge (
        .clk(clk), .rst(rst), .d(match), .rise(match_rise)
    );
    edge_rise #(.RST_VAL(1'b1)) u_snooze_edge (
        .clk(clk), .rst(rst), .d(snooze), .rise(snooze_rise)
    );
    edge_rise #(.RST_VAL(1'b1)) u_dismiss_edge (
        .clk(clk), .rst(rst), .d(dismiss), .rise(dismiss_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tmr      <= '0;
            phase    <= 1'b0;
            snz_left <= SNZ_INIT;
            buzz     <= 1'b0;
            ringing  <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            phase    <= phase_n;
            snz_left <= snz_n;
            buzz     <= (state_n == RING) & phase_n;
            ringing  <= (state_n == RING);
        end
    end

    // Button checks precede the tick branch, so an acting button swallows a coincident tick.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        phase_n = phase;
        snz_n   = snz_left;
        if (!alarm_on) begin
            state_n = IDLE;
            tmr_n   = '0;
            phase_n = 1'b0;
            snz_n   = SNZ_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match_rise && day_enabled(DAY_MASK, day)) begin
                        state_n = RING;
                        tmr_n   = '0;
                        phase_n = 1'b1;
                        snz_n   = SNZ_INIT;
                    end
                end
                RING: begin
                    if (dismiss_rise) begin
                        state_n = DONE;
                        tmr_n   = '0;
                    end else if (snooze_rise && snz_left != 2'd0) begin
                        state_n = SNOOZE;
                        tmr_n   = '0;
                        snz_n   = snz_left - 2'd1;
                    end else if (sec_tick) begin
                        if (tmr == RING_LAST) begin
                            tmr_n = '0;
                            if (snz_left != 2'd0) begin
                                state_n = SNOOZE;
                                snz_n   = snz_left - 2'd1;
                            end else begin
                                state_n = DONE;
                            end
                        end else begin
                            tmr_n   = tmr + 1'b1;
                            phase_n = ~phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss_rise) begin
                        state_n = DONE;
                        tmr_n   = '0;
                    end else if (sec_tick) begin
                        if (tmr == SNZ_LAST) begin
                            state_n = RING;
                            tmr_n   = '0;
                            phase_n = 1'b1;
                        end else begin
                            tmr_n = tmr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!match) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios then random traffic, all scored against a second-counting model.
module tb_alarm_ring_ctrl;

    localparam int RING_S   = 4;
    localparam int SNOOZE_S = 6;
    localparam int MAX_SNZ  = 2;
    localparam logic [6:0] TB_MASK = 7'b0011111;

    logic       clk = 1'b0;
    logic       rst, sec_tick, match, alarm_on, snooze, dismiss;
    logic [2:0] day;
    logic       buzz, ringing;
    logic [1:0] snz_left;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: event activity, quiet (snoozing) flag, seconds elapsed, and a
    // post-event hold that waits for the matching minute to end.
    bit m_active, m_quiet, m_hold;
    int m_secs, m_left;
    bit pm, ps, pd;
    bit exp_ring, exp_buzz;

    alarm_ring_ctrl #(
        .RING_S(RING_S),
        .SNOOZE_S(SNOOZE_S),
        .MAX_SNZ(MAX_SNZ),
        .DAY_MASK(TB_MASK)
    ) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .match(match),
        .alarm_on(alarm_on), .day(day), .snooze(snooze), .dismiss(dismiss),
        .buzz(buzz), .ringing(ringing), .snz_left(snz_left)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit day_ok(input logic [2:0] d);
        logic [7:0] mv;
        mv = {1'b0, TB_MASK};
        return mv[d];
    endfunction

    task automatic model_step();
        bit mr, sr, dr;
        mr = match && !pm;
        sr = snooze && !ps;
        dr = dismiss && !pd;
        if (!rst) begin
            m_active = 0; m_quiet = 0; m_hold = 0; m_secs = 0; m_left = MAX_SNZ;
            pm = 1; ps = 1; pd = 1;
        end else begin
            pm = match; ps = snooze; pd = dismiss;
            if (!alarm_on) begin
                m_active = 0; m_quiet = 0; m_hold = 0; m_secs = 0; m_left = MAX_SNZ;
            end else if (m_hold) begin
                if (!match) m_hold = 0;
            end else if (!m_active) begin
                if (mr && day_ok(day)) begin
                    m_active = 1; m_quiet = 0; m_secs = 0; m_left = MAX_SNZ;
                end
            end else if (dr) begin
                m_active = 0; m_hold = 1;
            end else if (!m_quiet) begin
                if (sr && m_left > 0) begin
                    m_quiet = 1; m_secs = 0; m_left--;
                end else if (sec_tick) begin
                    m_secs++;
                    if (m_secs == RING_S) begin
                        if (m_left > 0) begin
                            m_quiet = 1; m_secs = 0; m_left--;
                        end else begin
                            m_active = 0; m_hold = 1;
                        end
                    end
                end
            end else if (sec_tick) begin
                m_secs++;
                if (m_secs == SNOOZE_S) begin
                    m_quiet = 0; m_secs = 0;
                end
            end
        end
        exp_ring = m_active && !m_quiet;
        exp_buzz = exp_ring && (m_secs % 2 == 0);
    endtask

    task automatic step();
        sec_tick = (cyc % 4 == 3);
        @(posedge clk);
        model_step();
        #1;
        check_eq("buzz", int'(buzz), int'(exp_buzz));
        check_eq("ringing", int'(ringing), int'(exp_ring));
        check_eq("snz_left", int'(snz_left), m_left);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic off_tick();
        while (cyc % 4 == 3) step();
    endtask

    task automatic press_snooze();
        off_tick();
        snooze = 1; step(); snooze = 0;
    endtask

    task automatic press_dismiss();
        off_tick();
        dismiss = 1; step(); dismiss = 0;
    endtask

    task automatic wait_ring(input int budget);
        int n;
        n = 0;
        while (!exp_ring && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_ring", int'(exp_ring), 1);
    endtask

    task automatic end_event();
        press_dismiss();
        match = 0;
        run(3);
    endtask

    initial begin
        rst = 0; alarm_on = 1; match = 0; day = 3'd2; snooze = 0; dismiss = 0; sec_tick = 0;
        run(3);
        check_eq("rst_buzz", int'(buzz), 0);
        check_eq("rst_ringing", int'(ringing), 0);
        check_eq("rst_snz", int'(snz_left), MAX_SNZ);
        rst = 1;
        run(2);

        // Day gate and beep pattern
        day = 3'd2; match = 1; step();
        check_eq("gate_d2", int'(ringing), 1);
        check_eq("first_buzz", int'(buzz), 1);
        run(18);
        end_event();
        day = 3'd5; match = 1; run(8);
        check_eq("gate_d5", int'(ringing), 0);
        match = 0; run(2);

        // Snooze, re-ring, exhaust snoozes
        day = 3'd1; match = 1; run(2);
        press_snooze();
        check_eq("snz1_left", int'(snz_left), 1);
        check_eq("snz1_quiet", int'(ringing), 0);
        wait_ring(40);
        press_snooze();
        check_eq("snz2_left", int'(snz_left), 0);
        wait_ring(40);
        press_snooze();
        check_eq("snz3_ignored", int'(ringing), 1);
        end_event();

        // Timeout chain into DONE, no re-ring while match stays high
        day = 3'd0; match = 1; run(110);
        check_eq("chain_done", int'(ringing), 0);
        run(20);
        check_eq("done_hold", int'(ringing), 0);
        match = 0; run(2);
        match = 1; step();
        check_eq("retrigger", int'(ringing), 1);
        end_event();

        // Dismiss beats snooze; alarm_on low restores snoozes
        day = 3'd3; match = 1; run(3);
        off_tick();
        dismiss = 1; snooze = 1; step(); dismiss = 0; snooze = 0;
        check_eq("prio_ring", int'(ringing), 0);
        check_eq("prio_snz", int'(snz_left), MAX_SNZ);
        match = 0; run(2);
        match = 1; run(2);
        press_snooze();
        run(5);
        alarm_on = 0; step();
        check_eq("off_snz", int'(snz_left), MAX_SNZ);
        check_eq("off_ring", int'(ringing), 0);
        alarm_on = 1; match = 0; run(2);

        // Reset mid-ring with match held
        day = 3'd4; match = 1; run(3);
        rst = 0; step();
        check_eq("midrst_ring", int'(ringing), 0);
        check_eq("midrst_buzz", int'(buzz), 0);
        rst = 1; run(20);
        check_eq("post_rst", int'(ringing), 0);
        match = 0; step();
        match = 1; step();
        check_eq("post_rst_rise", int'(ringing), 1);
        end_event();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            alarm_on = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) match = ~match;
            if ($urandom_range(0, 29) == 0) day = 3'($urandom_range(0, 6));
            snooze  = (cyc % 4 != 3) && ($urandom_range(0, 14) == 0);
            dismiss = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
